// File: rtl/pac_rr_requester_pkg.sv
// Shared types and register map for the PAC-RR requester.
package pac_rr_pkg;

    localparam int PAC_NUM_CH = 4;

    typedef enum logic [1:0] {REQ_IDLE, REQ_XFER, REQ_GAP} pac_req_state_e;

    localparam logic [3:0] PAC_REQ_ADDR_LEN0   = 4'h0;
    localparam logic [3:0] PAC_REQ_ADDR_LEN1   = 4'h1;
    localparam logic [3:0] PAC_REQ_ADDR_LEN2   = 4'h2;
    localparam logic [3:0] PAC_REQ_ADDR_LEN3   = 4'h3;
    localparam logic [3:0] PAC_REQ_ADDR_ENQ    = 4'h4;
    localparam logic [3:0] PAC_REQ_ADDR_CLR    = 4'h5;
    localparam logic [3:0] PAC_REQ_ADDR_PEND01 = 4'h6;
    localparam logic [3:0] PAC_REQ_ADDR_PEND23 = 4'h7;
    localparam logic [3:0] PAC_REQ_ADDR_STATUS = 4'h8;
    localparam logic [3:0] PAC_REQ_ADDR_BEAT   = 4'h9;
    localparam logic [3:0] PAC_REQ_ADDR_STAT0  = 4'hC;
    localparam logic [3:0] PAC_REQ_ADDR_STAT1  = 4'hD;
    localparam logic [3:0] PAC_REQ_ADDR_STAT2  = 4'hE;
    localparam logic [3:0] PAC_REQ_ADDR_STAT3  = 4'hF;

endpackage

// File: rtl/pac_rr_requester_if.sv
// Arbiter request/grant and sink valid/ready bundle for the PAC-RR requester.
interface pac_rr_requester_if;

    logic [3:0] req_o;
    logic [3:0] grant_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i;

    modport master (output req_o, output valid_o, output data_o,
                    input grant_i, input ready_i);
    modport slave  (input req_o, input valid_o, input data_o,
                    output grant_i, output ready_i);

endinterface

// File: rtl/pac_rr_requester_chan.sv
// Per-channel pending-job counter with saturation/overflow and GAP-masked request.
module pac_rr_req_chan
    import pac_rr_pkg::*;
#(
    parameter int PEND_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enq,
    input  logic              dec,
    input  logic              flush,
    input  logic              mask_n,
    output logic [PEND_W-1:0] pend,
    output logic              req,
    output logic              ovf_set
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_n;

    // Enqueue and completion in the same cycle cancel out.
    always_comb begin
        pend_n  = pend;
        ovf_set = 1'b0;
        if (flush) begin
            pend_n = '0;
        end else if (enq && !dec) begin
            if (pend == PEND_MAX) ovf_set = 1'b1;
            else                  pend_n  = pend + 1'b1;
        end else if (dec && !enq) begin
            if (pend != '0) pend_n = pend - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend <= '0;
            req  <= 1'b0;
        end else begin
            pend <= pend_n;
            req  <= (pend_n != '0) && !mask_n;
        end
    end

endmodule

// File: rtl/pac_rr_requester.sv
// PAC-RR requester: register port, grant-driven burst FSM and beat streaming.
// Optional per-channel completed-burst counters under PAC_RR_REQ_STATS_EN.
//
// state    | meaning
// REQ_IDLE | waiting for a one-hot grant on a requesting channel
// REQ_XFER | streaming beats of the active channel's burst
// REQ_GAP  | one cycle with the finished channel's request masked
module pac_rr_requester
    import pac_rr_pkg::*;
#(
    parameter int PEND_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         address,
    input  logic               data_write,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    pac_rr_requester_if.master bus
);

    pac_req_state_e state, state_n;
    logic [1:0] act, act_n;
    logic [2:0] beat, beat_n;
    logic [2:0] burst_len [PAC_NUM_CH];
    logic       ovf, mgnt, last;
    logic       valid_q;
    logic [7:0] data_q;

    logic [PAC_NUM_CH-1:0] req_q, enq, dec, flush, mask_n, ovf_set;
    logic [PEND_W-1:0]     pend [PAC_NUM_CH];
    logic [3:0]            pend_nib [PAC_NUM_CH];

    logic       wr_enq, wr_clr, grant_multi, grant_one;
    logic [1:0] grant_idx;
    logic [7:0] stat_rd;
    wire        unused_data = &{1'b0, data_in[7:4]};

    assign wr_enq      = data_write && (address == PAC_REQ_ADDR_ENQ);
    assign wr_clr      = data_write && (address == PAC_REQ_ADDR_CLR);
    assign grant_multi = (bus.grant_i & (bus.grant_i - 4'd1)) != 4'd0;
    assign grant_one   = (bus.grant_i != 4'd0) && !grant_multi;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < PAC_NUM_CH; i++)
            if (bus.grant_i[i]) grant_idx = 2'(i);
    end

    always_comb begin
        state_n = state;
        act_n   = act;
        beat_n  = beat;
        last    = 1'b0;
        unique case (state)
            REQ_IDLE: if (grant_one && ((bus.grant_i & req_q) != 4'd0)) begin
                state_n = REQ_XFER;
                act_n   = grant_idx;
                beat_n  = '0;
            end
            REQ_XFER: if (bus.ready_i) begin
                if (beat == burst_len[act]) begin
                    state_n = REQ_GAP;
                    last    = 1'b1;
                end else begin
                    beat_n = beat + 3'd1;
                end
            end
            REQ_GAP:  state_n = REQ_IDLE;
            default:  state_n = REQ_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= REQ_IDLE;
            act     <= '0;
            beat    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf     <= 1'b0;
            mgnt    <= 1'b0;
            for (int i = 0; i < PAC_NUM_CH; i++) burst_len[i] <= '0;
        end else begin
            state   <= state_n;
            act     <= act_n;
            beat    <= beat_n;
            valid_q <= (state_n == REQ_XFER);
            data_q  <= (state_n == REQ_XFER) ? {act_n, 3'b000, beat_n} : 8'h00;
            if (wr_clr && data_in[0]) begin
                ovf  <= 1'b0;
                mgnt <= 1'b0;
            end
            if (state == REQ_IDLE && grant_multi) mgnt <= 1'b1;
            if (|ovf_set) ovf <= 1'b1;
            if (data_write && address[3:2] == 2'b00) burst_len[address[1:0]] <= data_in[2:0];
        end
    end

    for (genvar c = 0; c < PAC_NUM_CH; c++) begin : g_chan
        assign enq[c]    = wr_enq && data_in[c];
        assign dec[c]    = last && (act == 2'(c));
        assign flush[c]  = wr_clr && data_in[1] && !(state == REQ_XFER && act == 2'(c));
        assign mask_n[c] = (state_n == REQ_GAP) && (act_n == 2'(c));
        assign pend_nib[c] = 4'(pend[c]);

        pac_rr_req_chan #(.PEND_W(PEND_W)) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .enq     (enq[c]),
            .dec     (dec[c]),
            .flush   (flush[c]),
            .mask_n  (mask_n[c]),
            .pend    (pend[c]),
            .req     (req_q[c]),
            .ovf_set (ovf_set[c])
        );
    end

`ifdef PAC_RR_REQ_STATS_EN
    logic [7:0] stats [PAC_NUM_CH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PAC_NUM_CH; i++) stats[i] <= '0;
        end else if (wr_clr && data_in[0]) begin
            for (int i = 0; i < PAC_NUM_CH; i++) stats[i] <= '0;
        end else if (last) begin
            stats[act] <= stats[act] + 8'd1;
        end
    end

    assign stat_rd = stats[address[1:0]];
`else
    assign stat_rd = 8'h00;
`endif

    always_comb begin
        data_out = 8'h00;
        case (address)
            PAC_REQ_ADDR_LEN0, PAC_REQ_ADDR_LEN1,
            PAC_REQ_ADDR_LEN2, PAC_REQ_ADDR_LEN3:
                data_out = {5'b00000, burst_len[address[1:0]]};
            PAC_REQ_ADDR_PEND01: data_out = {pend_nib[1], pend_nib[0]};
            PAC_REQ_ADDR_PEND23: data_out = {pend_nib[3], pend_nib[2]};
            PAC_REQ_ADDR_STATUS: data_out = {req_q, act, ovf, mgnt};
            PAC_REQ_ADDR_BEAT:   data_out = {state != REQ_IDLE, 4'b0000, beat};
            PAC_REQ_ADDR_STAT0, PAC_REQ_ADDR_STAT1,
            PAC_REQ_ADDR_STAT2, PAC_REQ_ADDR_STAT3:
                data_out = stat_rd;
            default: data_out = 8'h00;
        endcase
    end

    assign bus.req_o   = req_q;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;

endmodule

// File: tb/tb_pac_rr_requester.sv
// Directed bench for pac_rr_requester with a cycle-level behavioural model.
module tb_pac_rr_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    pac_rr_requester_if bus();

    pac_rr_requester #(.PEND_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pending jobs, lengths, and "which beat of which channel is on the wire".
    int         m_pend [4];
    logic [2:0] m_len [4];
    logic [7:0] m_stats [4];
    logic [3:0] m_req;
    logic       m_valid, m_gap, m_ovf, m_mgnt, m_done;
    logic [1:0] m_act;
    logic [2:0] m_beat;
    int         m_gcnt, m_gk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_pend[c] = 0; m_len[c] = 3'd0; m_stats[c] = 8'd0;
            end
            m_req = 4'd0; m_valid = 1'b0; m_gap = 1'b0; m_ovf = 1'b0; m_mgnt = 1'b0;
            m_act = 2'd0; m_beat = 3'd0;
        end else begin
            m_done = m_valid && bus.ready_i && (m_beat == m_len[m_act]);
            for (int c = 0; c < 4; c++) begin
                if (data_write && address == 4'h5 && data_in[1] && !(m_valid && m_act == 2'(c)))
                    m_pend[c] = 0;
                else if (data_write && address == 4'h4 && data_in[c] && !(m_done && m_act == 2'(c))) begin
                    if (m_pend[c] == 15) m_ovf = 1'b1;
                    else m_pend[c] = m_pend[c] + 1;
                end else if (m_done && m_act == 2'(c) && !(data_write && address == 4'h4 && data_in[c])) begin
                    if (m_pend[c] > 0) m_pend[c] = m_pend[c] - 1;
                end
            end
            if (data_write && address == 4'h5 && data_in[0]) begin
                m_ovf = 1'b0; m_mgnt = 1'b0;
                for (int c = 0; c < 4; c++) m_stats[c] = 8'd0;
            end else if (m_done) begin
                m_stats[m_act] = m_stats[m_act] + 8'd1;
            end
            m_gcnt = 0; m_gk = 0;
            for (int c = 0; c < 4; c++) if (bus.grant_i[c]) begin m_gcnt++; m_gk = c; end
            if (m_valid) begin
                if (m_done) begin m_valid = 1'b0; m_gap = 1'b1; end
                else if (bus.ready_i) m_beat = m_beat + 3'd1;
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_gcnt == 1 && m_req[m_gk]) begin
                m_valid = 1'b1; m_act = 2'(m_gk); m_beat = 3'd0;
            end else if (m_gcnt > 1) begin
                m_mgnt = 1'b1;
            end
            if (data_write && address < 4'h4) m_len[address[1:0]] = data_in[2:0];
            for (int c = 0; c < 4; c++) m_req[c] = (m_pend[c] != 0) && !(m_gap && m_act == 2'(c));
        end
    end

    function automatic logic [7:0] m_data();
        return m_valid ? {m_act, 3'b000, m_beat} : 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        logic [7:0] r;
        r = 8'h00;
        case (a)
            4'h0, 4'h1, 4'h2, 4'h3: r = {5'b0, m_len[a[1:0]]};
            4'h6: r = {4'(m_pend[1]), 4'(m_pend[0])};
            4'h7: r = {4'(m_pend[3]), 4'(m_pend[2])};
            4'h8: r = {m_req, m_act, m_ovf, m_mgnt};
            4'h9: r = {m_valid || m_gap, 4'b0000, m_beat};
`ifdef PAC_RR_REQ_STATS_EN
            4'hC, 4'hD, 4'hE, 4'hF: r = m_stats[a[1:0]];
`endif
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic       prev_valid = 1'b0, prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] acc [$];
    logic       q_valid [$];
    logic       q_req0 [$];

    task automatic tick();
        @(negedge clk);
        check("req_o", {28'd0, bus.req_o}, {28'd0, m_req});
        check("valid_o", {31'd0, bus.valid_o}, {31'd0, m_valid});
        check("data_o", {24'd0, bus.data_o}, {24'd0, m_data()});
        check("data_out", {24'd0, data_out}, {24'd0, m_read(address)});
        if (!rst && prev_valid && !prev_ready)
            check("hold", {23'd0, bus.valid_o, bus.data_o}, {23'd0, 1'b1, prev_data});
        if (bus.valid_o && bus.ready_i) acc.push_back(bus.data_o);
        q_valid.push_back(bus.valid_o);
        q_req0.push_back(bus.req_o[0]);
        prev_valid = bus.valid_o;
        prev_ready = bus.ready_i;
        prev_data  = bus.data_o;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(name, {24'd0, data_out}, {24'd0, exp});
    endtask

    task automatic acc_chk(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, acc.size(), n);
        for (int i = 0; i < n && i < acc.size(); i++)
            check(name, {24'd0, acc[i]}, {24'd0, e[i]});
    endtask

    initial begin
        int f, l, lows;
        bus.grant_i = 4'd0;
        bus.ready_i = 1'b0;

        // Reset state
        tick();
        check("rst_req", {28'd0, bus.req_o}, 32'd0);
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        tick();
        rst = 1'b0;
        rd_chk("rst_status", 4'h8, 8'h00);

        // Ch2 four-beat burst
        wr(4'h2, 8'h03);
        wr(4'h4, 8'h04);
        bus.grant_i = 4'b0100;
        bus.ready_i = 1'b1;
        rd_chk("enq_status", 4'h8, 8'h40);
        acc.delete();
        repeat (8) tick();
        acc_chk("burst_ch2", 8'h80, 8'h81, 8'h82, 8'h83, 4);
        rd_chk("ch2_done_status", 4'h8, 8'h08);
        rd_chk("ch2_pend", 4'h7, 8'h00);
        rd_chk("len2_read", 4'h2, 8'h03);
        rd_chk("unmapped_a", 4'hA, 8'h00);
        bus.grant_i = 4'd0;

        // Two ch0 bursts with toggling ready
        wr(4'h0, 8'h01);
        wr(4'h4, 8'h01);
        wr(4'h4, 8'h01);
        acc.delete(); q_valid.delete(); q_req0.delete();
        bus.grant_i = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            bus.ready_i = (i % 2 == 0);
            tick();
        end
        acc_chk("burst_ch0x2", 8'h00, 8'h01, 8'h00, 8'h01, 4);
        f = -1; l = -1; lows = 0;
        for (int i = 0; i < q_valid.size(); i++)
            if (q_valid[i]) begin
                if (f < 0) f = i;
                l = i;
            end
        for (int i = f + 1; i < l; i++) if (!q_req0[i]) lows++;
        check("req0_gap_cycles", lows, 1);
        bus.grant_i = 4'd0;
        bus.ready_i = 1'b1;

        // Multi-hot grant
        wr(4'h4, 8'h03);
        bus.grant_i = 4'b0011;
        repeat (3) tick();
        rd_chk("mgnt_set", 4'h8, 8'h31);
        bus.grant_i = 4'd0;
        wr(4'h5, 8'h01);
        rd_chk("mgnt_clr", 4'h8, 8'h30);
        wr(4'h5, 8'h02);
        rd_chk("flush_idle", 4'h6, 8'h00);

        // Overflow on ch1
        repeat (16) wr(4'h4, 8'h02);
        rd_chk("pend1_sat", 4'h6, 8'hF0);
        rd_chk("ovf_set", 4'h8, 8'h22);
        wr(4'h5, 8'h03);
        rd_chk("ovf_clr", 4'h8, 8'h00);

        // Flush during active ch0 burst with ch3 pending
        wr(4'h0, 8'h03);
        wr(4'h4, 8'h09);
        bus.grant_i = 4'b0001;
        acc.delete();
        tick();
        wr(4'h5, 8'h02);
        repeat (6) tick();
        acc_chk("burst_flush", 8'h00, 8'h01, 8'h02, 8'h03, 4);
        rd_chk("flush_pend3", 4'h7, 8'h00);
        rd_chk("flush_pend0", 4'h6, 8'h00);
        bus.grant_i = 4'd0;

        // Reset mid-burst
        wr(4'h4, 8'h01);
        bus.grant_i = 4'b0001;
        tick();
        tick();
        check("midburst_valid", {31'd0, bus.valid_o}, 32'd1);
        address = 4'h8;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_mid_data", {24'd0, bus.data_o}, 32'd0);
        check("rst_mid_req", {28'd0, bus.req_o}, 32'd0);
        check("rst_mid_status", {24'd0, data_out}, 32'd0);
        tick();
        rst = 1'b0;
        bus.grant_i = 4'd0;

        // Three ch1 bursts for the completion counter
        repeat (3) wr(4'h4, 8'h02);
        bus.grant_i = 4'b0010;
        repeat (12) tick();
`ifdef PAC_RR_REQ_STATS_EN
        rd_chk("stats_ch1", 4'hD, 8'h03);
`else
        rd_chk("stats_absent", 4'hD, 8'h00);
`endif
        rd_chk("pend1_drained", 4'h6, 8'h00);
        bus.grant_i = 4'd0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
